// File: rtl/data_mem_controller.sv
// data_mem_controller: load/store sequencer for a byte-addressable, word-wide
// data memory. It decodes RV32I funct3, issues word-aligned accesses with
// lane enables, and splits accesses that cross a word boundary into two.
// It sign- or zero-extends load data and returns one response pulse per
// request.
// All outputs are registered: the values for the next state are computed
// combinationally and loaded on the clock edge that enters that state.
// Optional feature macro: MEM_MISALIGN_FAULT_EN. When it is defined, every
// access that is not naturally aligned faults and is never split.
module data_mem_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic [3:0]  mem_read_byte_en,
  output logic [3:0]  mem_write_byte_en,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  // Byte-lane mask over two consecutive words for a given size and offset.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] base;
    case (size)
      2'd0:    base = 4'b0001;
      2'd1:    base = 4'b0011;
      2'd2:    base = 4'b1111;
      default: base = 4'b0000;
    endcase
    return {4'b0000, base} << off;
  endfunction

  // Funct3 encodings that have no meaning for the given direction.
  function automatic logic illegal_funct3(input logic write, input logic [2:0] f3);
    logic bad;
    if (write) begin
      bad = f3[2] || (f3[1:0] == 2'd3);
    end else begin
      bad = (f3[1:0] == 2'd3) || (f3 == 3'd6);
    end
    return bad;
  endfunction

  // Pick the addressed bytes out of the {hi,lo} pair and extend them to 32 bits.
  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] hi, input logic [31:0] lo);
    logic [63:0] sh;
    logic [31:0] res;
    sh = {hi, lo} >> {off, 3'b000};
    case (f3[1:0])
      2'd0:    res = f3[2] ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'd1:    res = f3[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      2'd2:    res = sh[31:0];
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  state_t      state_r, state_nx_s;
  logic        ready_r, ready_nx_s;
  logic        write_r, fault_r;
  logic [2:0]  funct3_r;
  logic [31:0] addr_r, wdata_r;
  logic [31:0] lo_r, hi_r, lo_nx_s, hi_nx_s;
  logic        resp_valid_r, resp_valid_nx_s;
  logic        resp_fault_r, resp_fault_nx_s;
  logic [31:0] resp_rdata_r, resp_rdata_nx_s;
  logic [31:0] mem_address_r, mem_address_nx_s;
  logic [31:0] mem_data_in_r, mem_data_in_nx_s;
  logic [3:0]  mem_re_r, mem_re_nx_s;
  logic [3:0]  mem_we_r, mem_we_nx_s;

  logic        accept_s;
  logic        cur_write_s;
  logic [2:0]  cur_funct3_s;
  logic [31:0] cur_addr_s, cur_wdata_s;
  logic        cur_fault_s;
  logic        misalign_s;
  logic [7:0]  mask_s;
  logic        cross_s;

  assign accept_s = req_valid && ready_r && (state_r == IDLE);

  // Request fields in use: live inputs on the accept cycle, latched copy afterwards.
  always_comb begin
    if (accept_s) begin
      cur_write_s  = req_write;
      cur_funct3_s = req_funct3;
      cur_addr_s   = req_addr;
      cur_wdata_s  = req_wdata;
    end else begin
      cur_write_s  = write_r;
      cur_funct3_s = funct3_r;
      cur_addr_s   = addr_r;
      cur_wdata_s  = wdata_r;
    end
  end

  // Natural-alignment check; only enforced when the misalignment fault option is built in.
  always_comb begin
`ifdef MEM_MISALIGN_FAULT_EN
    misalign_s = ((cur_funct3_s[1:0] == 2'd1) && cur_addr_s[0]) ||
                 ((cur_funct3_s[1:0] == 2'd2) && (cur_addr_s[1:0] != 2'd0));
`else
    misalign_s = 1'b0;
`endif
  end

  assign cur_fault_s = accept_s ? (illegal_funct3(req_write, req_funct3) || misalign_s) : fault_r;
  assign mask_s      = lane_mask(cur_funct3_s[1:0], cur_addr_s[1:0]);
  assign cross_s     = |mask_s[7:4];

  // Next-state selection, read-buffer capture and next values of the registered outputs.
  always_comb begin
    state_nx_s       = state_r;
    ready_nx_s       = 1'b0;
    lo_nx_s          = lo_r;
    hi_nx_s          = hi_r;
    resp_valid_nx_s  = 1'b0;
    resp_fault_nx_s  = 1'b0;
    resp_rdata_nx_s  = 32'd0;
    mem_address_nx_s = 32'd0;
    mem_data_in_nx_s = 32'd0;
    mem_re_nx_s      = 4'd0;
    mem_we_nx_s      = 4'd0;

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          lo_nx_s = 32'd0;
          hi_nx_s = 32'd0;
          if (cur_fault_s) begin
            state_nx_s = RESP;
          end else begin
            state_nx_s = ACC0;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      ACC0: begin
        if (!cur_write_s) begin
          lo_nx_s = mem_data_out;
        end else begin
          lo_nx_s = lo_r;
        end
        if (cross_s) begin
          state_nx_s = ACC1;
        end else begin
          state_nx_s = RESP;
        end
      end
      ACC1: begin
        if (!cur_write_s) begin
          hi_nx_s = mem_data_out;
        end else begin
          hi_nx_s = hi_r;
        end
        state_nx_s = RESP;
      end
      RESP: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase

    case (state_nx_s)
      IDLE: begin
        ready_nx_s = 1'b1;
      end
      ACC0: begin
        mem_address_nx_s = {cur_addr_s[31:2], 2'b00};
        if (cur_write_s) begin
          mem_we_nx_s      = mask_s[3:0];
          mem_data_in_nx_s = cur_wdata_s << {cur_addr_s[1:0], 3'b000};
        end else begin
          mem_re_nx_s = mask_s[3:0];
        end
      end
      ACC1: begin
        // Adding 4 to the aligned address wraps the top word back to 0.
        mem_address_nx_s = {cur_addr_s[31:2], 2'b00} + 32'd4;
        if (cur_write_s) begin
          mem_we_nx_s      = mask_s[7:4];
          mem_data_in_nx_s = cur_wdata_s >> (6'd32 - {1'b0, cur_addr_s[1:0], 3'b000});
        end else begin
          mem_re_nx_s = mask_s[7:4];
        end
      end
      RESP: begin
        resp_valid_nx_s = 1'b1;
        resp_fault_nx_s = cur_fault_s;
        if (!cur_write_s && !cur_fault_s) begin
          resp_rdata_nx_s = extend_load(cur_funct3_s, cur_addr_s[1:0], hi_nx_s, lo_nx_s);
        end else begin
          resp_rdata_nx_s = 32'd0;
        end
      end
      default: begin
        ready_nx_s = 1'b0;
      end
    endcase
  end

  // State, latched request, read buffers and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      ready_r       <= 1'b0;
      write_r       <= 1'b0;
      fault_r       <= 1'b0;
      funct3_r      <= 3'd0;
      addr_r        <= 32'd0;
      wdata_r       <= 32'd0;
      lo_r          <= 32'd0;
      hi_r          <= 32'd0;
      resp_valid_r  <= 1'b0;
      resp_fault_r  <= 1'b0;
      resp_rdata_r  <= 32'd0;
      mem_address_r <= 32'd0;
      mem_data_in_r <= 32'd0;
      mem_re_r      <= 4'd0;
      mem_we_r      <= 4'd0;
    end else begin
      state_r       <= state_nx_s;
      ready_r       <= ready_nx_s;
      if (accept_s) begin
        write_r  <= req_write;
        funct3_r <= req_funct3;
        addr_r   <= req_addr;
        wdata_r  <= req_wdata;
        fault_r  <= cur_fault_s;
      end else begin
        write_r  <= write_r;
        funct3_r <= funct3_r;
        addr_r   <= addr_r;
        wdata_r  <= wdata_r;
        fault_r  <= fault_r;
      end
      lo_r          <= lo_nx_s;
      hi_r          <= hi_nx_s;
      resp_valid_r  <= resp_valid_nx_s;
      resp_fault_r  <= resp_fault_nx_s;
      resp_rdata_r  <= resp_rdata_nx_s;
      mem_address_r <= mem_address_nx_s;
      mem_data_in_r <= mem_data_in_nx_s;
      mem_re_r      <= mem_re_nx_s;
      mem_we_r      <= mem_we_nx_s;
    end
  end

  assign req_ready         = ready_r;
  assign resp_valid        = resp_valid_r;
  assign resp_fault        = resp_fault_r;
  assign resp_rdata        = resp_rdata_r;
  assign mem_address       = mem_address_r;
  assign mem_data_in       = mem_data_in_r;
  assign mem_read_byte_en  = mem_re_r;
  assign mem_write_byte_en = mem_we_r;

endmodule

// File: tb/tb_data_mem_controller.sv
// tb_data_mem_controller: directed, table-driven bench for data_mem_controller
// with a 256-byte behavioural memory. Expected values are hand-computed.
module tb_data_mem_controller;

`ifdef MEM_MISALIGN_FAULT_EN
  localparam bit MISAL = 1'b1;
`else
  localparam bit MISAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_read_byte_en;
  logic [3:0]  mem_write_byte_en;
  logic [31:0] mem_data_out;

  int total = 0;
  int bad = 0;

  logic [7:0] mem [0:255];
  bit init_done = 1'b0;

  logic [31:0] snap_addr [0:9];
  logic [31:0] snap_din [0:9];
  logic [3:0]  snap_we [0:9];
  logic [3:0]  snap_re [0:9];

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] er;
    logic        ef;
    int          el;
  } vec_t;
  vec_t vecs[$];

  data_mem_controller dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_funct3        (req_funct3),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_rdata        (resp_rdata),
    .resp_fault        (resp_fault),
    .mem_address       (mem_address),
    .mem_data_in       (mem_data_in),
    .mem_read_byte_en  (mem_read_byte_en),
    .mem_write_byte_en (mem_write_byte_en),
    .mem_data_out      (mem_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural memory: cleared before the test, then byte-lane writes on posedge.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (mem_write_byte_en[i]) mem[mem_address[7:0] + 8'(i)] <= mem_data_in[8*i +: 8];
      end
    end
  end

  // Combinational read port, byte index wraps within the 256-byte model.
  always_comb begin
    for (int i = 0; i < 4; i++) mem_data_out[8*i +: 8] = mem[mem_address[7:0] + 8'(i)];
  end

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", name, got, exp);
    end
  endtask

  task automatic add_vec(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] er, input logic ef, input int el);
    vecs.push_back('{w, f3, a, d, er, ef, el});
  endtask

  // Issue one request from a negedge and follow it to its response pulse.
  task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic flt, output int lat,
                         output logic any_en, output logic resp_mem_zero);
    int guard;
    guard = 0;
    rd = 32'd0; flt = 1'b0; lat = -1; any_en = 1'b0; resp_mem_zero = 1'b0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: req_ready stayed 0");
    end
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      snap_addr[k] = mem_address; snap_din[k] = mem_data_in;
      snap_we[k] = mem_write_byte_en; snap_re[k] = mem_read_byte_en;
      any_en = any_en | (|mem_write_byte_en) | (|mem_read_byte_en);
      if (resp_valid) begin
        rd = resp_rdata; flt = resp_fault; lat = k;
        resp_mem_zero = (mem_address == 32'd0) && (mem_data_in == 32'd0) &&
                        (mem_write_byte_en == 4'd0) && (mem_read_byte_en == 4'd0);
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        flt, any_en, mz;
    int          lat;

    // Stimulus table: {write, funct3, addr, wdata, expected rdata, fault, latency}.
    add_vec(1, 3'd2, 32'h010, 32'hDEADBEEF, 32'h0, 0, 2);
    add_vec(0, 3'd2, 32'h010, 32'h0, 32'hDEADBEEF, 0, 2);
    add_vec(1, 3'd0, 32'h013, 32'h12345680, 32'h0, 0, 2);
    add_vec(0, 3'd0, 32'h013, 32'h0, 32'hFFFFFF80, 0, 2);
    add_vec(0, 3'd4, 32'h013, 32'h0, 32'h00000080, 0, 2);
    add_vec(0, 3'd2, 32'h010, 32'h0, 32'h80ADBEEF, 0, 2);
    add_vec(0, 3'd1, 32'h012, 32'h0, 32'hFFFF80AD, 0, 2);
    add_vec(0, 3'd5, 32'h010, 32'h0, 32'h0000BEEF, 0, 2);
    add_vec(1, 3'd2, 32'h021, 32'h11223344, 32'h0, MISAL, MISAL ? 1 : 3);
    add_vec(0, 3'd2, 32'h021, 32'h0, MISAL ? 32'h0 : 32'h11223344, MISAL, MISAL ? 1 : 3);
    add_vec(0, 3'd1, 32'h023, 32'h0, MISAL ? 32'h0 : 32'h00001122, MISAL, MISAL ? 1 : 3);
    add_vec(0, 3'd0, 32'h024, 32'h0, MISAL ? 32'h0 : 32'h00000011, 0, 2);
    add_vec(0, 3'd3, 32'h010, 32'h0, 32'h0, 1, 1);
    add_vec(1, 3'd5, 32'h010, 32'hFFFFFFFF, 32'h0, 1, 1);
    add_vec(0, 3'd6, 32'h010, 32'h0, 32'h0, 1, 1);
    add_vec(0, 3'd2, 32'h010, 32'h0, 32'h80ADBEEF, 0, 2);
    add_vec(1, 3'd2, 32'h030, 32'hCAFEF00D, 32'h0, 0, 2);
    add_vec(0, 3'd1, 32'h032, 32'h0, 32'hFFFFCAFE, 0, 2);
    add_vec(0, 3'd1, 32'h031, 32'h0, MISAL ? 32'h0 : 32'hFFFFFEF0, MISAL, MISAL ? 1 : 2);
    add_vec(0, 3'd5, 32'h033, 32'h0, MISAL ? 32'h0 : 32'h000000CA, MISAL, MISAL ? 1 : 3);
    add_vec(1, 3'd2, 32'hFFFFFFFF, 32'hA1B2C3D4, 32'h0, MISAL, MISAL ? 1 : 3);
    add_vec(0, 3'd2, 32'h000, 32'h0, MISAL ? 32'h0 : 32'h00A1B2C3, 0, 2);

    // Reset state while reset is held low.
    repeat (3) @(negedge clk);
    init_done = 1'b1;
    check32("rst_ready", {31'd0, req_ready}, 32'd0);
    check32("rst_resp", {30'd0, resp_valid, resp_fault}, 32'd0);
    check32("rst_rdata", resp_rdata, 32'd0);
    check32("rst_mem_addr", mem_address, 32'd0);
    check32("rst_mem_en", {24'd0, mem_read_byte_en, mem_write_byte_en}, 32'd0);
    reset = 1'b1;
    #1 check32("ready_after_release", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check32("ready_one_cycle_later", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      run_req(vecs[i].w, vecs[i].f3, vecs[i].a, vecs[i].d, rd, flt, lat, any_en, mz);
      check32($sformatf("v%0d_rdata", i), rd, vecs[i].er);
      check32($sformatf("v%0d_fault", i), {31'd0, flt}, {31'd0, vecs[i].ef});
      check32($sformatf("v%0d_latency", i), lat, vecs[i].el);
      if (vecs[i].ef) begin
        check32($sformatf("v%0d_no_mem_enables", i), {31'd0, any_en}, 32'd0);
      end else begin
        check32($sformatf("v%0d_mem_idle_in_resp", i), {31'd0, mz}, 32'd1);
      end
    end

    // Aligned word store drives all four lanes in ACC0.
    run_req(1'b1, 3'd2, 32'h060, 32'h01020304, rd, flt, lat, any_en, mz);
    check32("sw_aligned_addr", snap_addr[1], 32'h060);
    check32("sw_aligned_we", {28'd0, snap_we[1]}, 32'hF);
    check32("sw_aligned_din", snap_din[1], 32'h01020304);

`ifndef MEM_MISALIGN_FAULT_EN
    // Split store lane/shift pattern in ACC0 and ACC1.
    run_req(1'b1, 3'd2, 32'h041, 32'h11223344, rd, flt, lat, any_en, mz);
    check32("split_acc0_addr", snap_addr[1], 32'h040);
    check32("split_acc0_we", {28'd0, snap_we[1]}, 32'hE);
    check32("split_acc0_din", snap_din[1], 32'h22334400);
    check32("split_acc0_re", {28'd0, snap_re[1]}, 32'h0);
    check32("split_acc1_addr", snap_addr[2], 32'h044);
    check32("split_acc1_we", {28'd0, snap_we[2]}, 32'h1);
    check32("split_acc1_din", snap_din[2], 32'h00000011);

    // Reset asserted during ACC1 of a split store.
    run_req(1'b1, 3'd0, 32'h054, 32'h00000077, rd, flt, lat, any_en, mz);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h051; req_wdata = 32'h11223344;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check32("acc1_we_before_reset", {28'd0, mem_write_byte_en}, 32'h1);
    reset = 1'b0;
    #1;
    check32("midrst_mem_en", {24'd0, mem_read_byte_en, mem_write_byte_en}, 32'd0);
    check32("midrst_mem_addr", mem_address, 32'd0);
    check32("midrst_mem_din", mem_data_in, 32'd0);
    check32("midrst_resp", {29'd0, req_ready, resp_valid, resp_fault}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 check32("midrst_ready_at_release", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check32("midrst_ready_next_cycle", {31'd0, req_ready}, 32'd1);
    check32("midrst_bytes_51_53", {8'd0, mem[8'h53], mem[8'h52], mem[8'h51]}, 32'h00223344);
    check32("midrst_byte_54", {24'd0, mem[8'h54]}, 32'h77);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
